// File: rtl/ins_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// ins_pkg : instruction word fields, opcodes and command encodings
// Revision: 1.0
// ------------------------------------------------------------------
package ins_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 12;
  localparam int SR_W   = 48;
  localparam int WORD_W = OP_W + 1 + DATA_W;

  localparam logic [OP_W-1:0] OP_NULL  = 3'b000;
  localparam logic [OP_W-1:0] OP_SETSR = 3'b001;
  localparam logic [OP_W-1:0] OP_LDSR  = 3'b010;
  localparam logic [OP_W-1:0] OP_MUX   = 3'b011;
  localparam logic [OP_W-1:0] OP_MUXE  = 3'b100;
  localparam logic [OP_W-1:0] OP_WAIT  = 3'b101;

  localparam logic [WORD_W-1:0] INS_NULL = {OP_NULL, 1'b0, {DATA_W{1'b0}}};

  typedef enum logic [1:0] {
    CMD_RAW  = 2'b00,
    CMD_MUX  = 2'b01,
    CMD_MUXE = 2'b10,
    CMD_WAIT = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SET  = 2'd1,
    ST_LD   = 2'd2,
    ST_OP   = 2'd3
  } ins_state_e;

  function automatic logic [WORD_W-1:0] ins_word(input logic [OP_W-1:0] op,
                                                 input logic ireg,
                                                 input logic [DATA_W-1:0] data);
    return {op, ireg, data};
  endfunction

  function automatic logic [DATA_W-1:0] sr_chunk(input logic [SR_W-1:0] value,
                                                 input logic [1:0] idx);
    return value[idx*DATA_W +: DATA_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ins_encoder_if.sv
`default_nettype none
// ------------------------------------------------------------------
// ins_encoder_if : command port and FIFO write port of ins_encoder
// Revision: 1.0
// ------------------------------------------------------------------
interface ins_encoder_if #(
  parameter int CNT_W = 16
);
  import ins_pkg::*;

  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic [1:0]          cmd_op_i;
  logic                cmd_ireg_i;
  logic [DATA_W-1:0]   cmd_data_i;
  logic [SR_W-1:0]     cmd_value_i;
  logic                fifo_full_i;
  logic                fifo_wr_o;
  logic [WORD_W-1:0]   fifo_data_o;
  logic                busy_o;
  logic [CNT_W-1:0]    word_cnt_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_ireg_i, cmd_data_i, cmd_value_i, fifo_full_i,
    output cmd_ready_o, fifo_wr_o, fifo_data_o, busy_o, word_cnt_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_ireg_i, cmd_data_i, cmd_value_i, fifo_full_i,
    input  cmd_ready_o, fifo_wr_o, fifo_data_o, busy_o, word_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/ins_chunk_cnt.sv
`default_nettype none
// ------------------------------------------------------------------
// ins_chunk_cnt : number of 12-bit chunks needed to load a 48-bit SR value
// INS_COMPRESS_EN selects leading-zero-chunk trimming; otherwise always 4.
// Revision: 1.0
// ------------------------------------------------------------------
module ins_chunk_cnt
  import ins_pkg::*;
(
  input  logic [SR_W-1:0] i_value,
  output logic [2:0]      o_n
);

`ifdef INS_COMPRESS_EN
  always_comb begin
    if (i_value[47:36] != '0) begin
      o_n = 3'd4;
    end else if (i_value[35:24] != '0) begin
      o_n = 3'd3;
    end else if (i_value[23:12] != '0) begin
      o_n = 3'd2;
    end else begin
      o_n = 3'd1;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^i_value;
  assign o_n      = 3'd4;
`endif

endmodule
`default_nettype wire

// File: rtl/ins_encoder.sv
`default_nettype none
// ------------------------------------------------------------------
// ins_encoder : expands RAW/MUX/MUXE/WAIT commands into SETSR/LDSR/op
// words for the instruction FIFO. Optional macro: INS_COMPRESS_EN.
// Revision: 1.0
// ------------------------------------------------------------------
module ins_encoder
  import ins_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic          fpga_clk_i,
  input  logic          reset_i,
  ins_encoder_if.slave  bus
);

  ins_state_e          r_state;
  ins_state_e          w_state_nxt;
  cmd_op_e             r_op;
  logic                r_ireg;
  logic [DATA_W-1:0]   r_data;
  logic [SR_W-1:0]     r_value;
  logic [1:0]          r_idx;
  logic [1:0]          w_idx_nxt;
  logic                r_ready;
  logic                w_ready_nxt;
  logic                r_wr;
  logic [WORD_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_accept;
  logic                w_emit;
  logic [WORD_W-1:0]   w_word;
  logic [WORD_W-1:0]   w_op_word;
  logic [2:0]          w_n;
  logic [1:0]          w_top_idx;
  logic [1:0]          w_set_idx;
  logic                w_hold;

  ins_chunk_cnt u_chunk_cnt (
    .i_value (r_value),
    .o_n     (w_n)
  );

  assign w_hold    = bus.fifo_full_i;
  assign w_top_idx = 2'(w_n - 3'd1);
  // MUXE preloads only the low chunk; WAIT starts at its most significant chunk
  assign w_set_idx = (r_op == CMD_WAIT) ? w_top_idx : 2'd0;

  always_comb begin
    w_op_word = INS_NULL;
    case (r_op)
      CMD_RAW:  w_op_word = r_value[WORD_W-1:0];
      CMD_MUX:  w_op_word = ins_word(OP_MUX, 1'b0, r_data);
      CMD_MUXE: w_op_word = ins_word(OP_MUXE, r_ireg, r_data);
      CMD_WAIT: w_op_word = ins_word(OP_WAIT, r_ireg, '0);
      default:  w_op_word = INS_NULL;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ready_nxt = r_ready;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    w_word      = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid_i && r_ready) begin
          w_accept    = 1'b1;
          w_ready_nxt = 1'b0;
          if (cmd_op_e'(bus.cmd_op_i) == CMD_MUXE || cmd_op_e'(bus.cmd_op_i) == CMD_WAIT) begin
            w_state_nxt = ST_SET;
          end else begin
            w_state_nxt = ST_OP;
          end
        end
      end
      ST_SET: begin
        w_word = ins_word(OP_SETSR, r_ireg, sr_chunk(r_value, w_set_idx));
        w_emit = ~w_hold;
        if (!w_hold) begin
          if (r_op == CMD_WAIT && w_n > 3'd1) begin
            w_idx_nxt   = w_top_idx - 2'd1;
            w_state_nxt = ST_LD;
          end else begin
            w_state_nxt = ST_OP;
          end
        end
      end
      ST_LD: begin
        w_word = ins_word(OP_LDSR, r_ireg, sr_chunk(r_value, r_idx));
        w_emit = ~w_hold;
        if (!w_hold) begin
          if (r_idx == 2'd0) begin
            w_state_nxt = ST_OP;
          end else begin
            w_idx_nxt = r_idx - 2'd1;
          end
        end
      end
      ST_OP: begin
        w_word = w_op_word;
        w_emit = ~w_hold;
        if (!w_hold) begin
          w_state_nxt = ST_IDLE;
          w_ready_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_op    <= CMD_RAW;
      r_ireg  <= 1'b0;
      r_data  <= '0;
      r_value <= '0;
    end else if (w_accept) begin
      r_op    <= cmd_op_e'(bus.cmd_op_i);
      r_ireg  <= bus.cmd_ireg_i;
      r_data  <= bus.cmd_data_i;
      r_value <= bus.cmd_value_i;
    end
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr    <= 1'b0;
      r_wdata <= INS_NULL;
      r_cnt   <= '0;
    end else begin
      r_wr <= w_emit;
      if (w_emit) begin
        r_wdata <= w_word;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.cmd_ready_o = r_ready;
  assign bus.busy_o      = ~r_ready;
  assign bus.fifo_wr_o   = r_wr;
  assign bus.fifo_data_o = r_wdata;
  assign bus.word_cnt_o  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ins_encoder.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ins_encoder : directed and random commands against a word-list model
// Revision: 1.0
// ------------------------------------------------------------------
module tb_ins_encoder;

  logic fpga_clk_i = 1'b0;
  logic reset_i    = 1'b1;

  ins_encoder_if #(.CNT_W(16)) bus ();

  ins_encoder #(.CNT_W(16)) dut (
    .fpga_clk_i (fpga_clk_i),
    .reset_i    (reset_i),
    .bus        (bus)
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] xq[$];
  logic [15:0] pend[$];
  logic [15:0] act[$];
  logic        acc_now  = 1'b0;
  logic        mon_en   = 1'b0;
  logic        rnd_full = 1'b0;
  logic [15:0] mcnt     = 16'd0;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference expansion straight from the command definitions
  function automatic void expand(input logic [1:0] op, input logic ireg,
                                 input logic [11:0] data, input logic [47:0] value);
    logic [11:0] c[4];
    int n;
    for (int i = 0; i < 4; i++) c[i] = value[12*i +: 12];
    case (op)
      2'd0: xq.push_back(value[15:0]);
      2'd1: xq.push_back({3'b011, 1'b0, data});
      2'd2: begin
        xq.push_back({3'b001, ireg, c[0]});
        xq.push_back({3'b100, ireg, data});
      end
      default: begin
`ifdef INS_COMPRESS_EN
        n = 1;
        for (int i = 1; i < 4; i++) if (c[i] != 12'h000) n = i + 1;
`else
        n = 4;
`endif
        xq.push_back({3'b001, ireg, c[n-1]});
        for (int j = n - 2; j >= 0; j--) xq.push_back({3'b010, ireg, c[j]});
        xq.push_back({3'b101, ireg, 12'h000});
      end
    endcase
  endfunction

  task automatic pin(input string nm, input int n, input logic [79:0] e);
    check({nm, "_len"}, xq.size(), n);
    for (int i = 0; i < n && i < xq.size(); i++) check(nm, {16'h0, xq[i]}, {16'h0, e[79-16*i -: 16]});
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge
  task automatic send(input logic [1:0] op, input logic ireg,
                      input logic [11:0] data, input logic [47:0] value);
    int guard = 0;
    bus.cmd_op_i    = op;
    bus.cmd_ireg_i  = ireg;
    bus.cmd_data_i  = data;
    bus.cmd_value_i = value;
    bus.cmd_valid_i = 1'b1;
    while (!bus.cmd_ready_o && guard < 300) begin
      @(negedge fpga_clk_i);
      guard++;
    end
    if (guard >= 300) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout got ready=0 expected ready=1 within 300 cycles");
      bus.cmd_valid_i = 1'b0;
      return;
    end
    xq.delete();
    expand(op, ireg, data, value);
    while (xq.size() > 0) pend.push_back(xq.pop_front());
    acc_now = 1'b1;
    @(negedge fpga_clk_i);
  endtask

  task automatic idle(input int k);
    bus.cmd_valid_i = 1'b0;
    repeat (k) @(negedge fpga_clk_i);
  endtask

  always @(negedge fpga_clk_i) if (rnd_full) bus.fifo_full_i = ($urandom_range(3) == 0);

  // Compare process: one word per non-full edge while a sequence is outstanding
  initial begin
    logic full_e, acc_e, exp_wr, exp_rdy;
    logic [15:0] w;
    forever begin
      @(posedge fpga_clk_i);
      full_e = bus.fifo_full_i;
      acc_e  = acc_now;
      #1;
      if (mon_en) begin
        if (acc_e) begin
          acc_now = 1'b0;
          while (pend.size() > 0) act.push_back(pend.pop_front());
          exp_wr = 1'b0;
        end else begin
          exp_wr = (act.size() > 0) && !full_e;
        end
        check("wr", {31'h0, bus.fifo_wr_o}, {31'h0, exp_wr});
        if (exp_wr) begin
          w = act.pop_front();
          mcnt = mcnt + 16'd1;
          if (bus.fifo_wr_o) check("data", {16'h0, bus.fifo_data_o}, {16'h0, w});
        end
        check("cnt", {16'h0, bus.word_cnt_o}, {16'h0, mcnt});
        exp_rdy = (act.size() == 0) && !acc_e;
        check("ready", {31'h0, bus.cmd_ready_o}, {31'h0, exp_rdy});
        check("busy", {31'h0, bus.busy_o}, {31'h0, ~exp_rdy});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] v;
    logic [1:0]  op;
    int          guard;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = 2'd0;
    bus.cmd_ireg_i  = 1'b0;
    bus.cmd_data_i  = 12'h0;
    bus.cmd_value_i = 48'h0;
    bus.fifo_full_i = 1'b0;

    xq.delete(); expand(2'd1, 1'b0, 12'hABC, 48'h0);       pin("m_mux",  1, {16'h6ABC, 64'h0});
    xq.delete(); expand(2'd2, 1'b1, 12'h012, 48'h5A5);     pin("m_muxe", 2, {16'h35A5, 16'h9012, 48'h0});
    xq.delete(); expand(2'd0, 1'b0, 12'h0, 48'hBEEF);      pin("m_raw",  1, {16'hBEEF, 64'h0});
    xq.delete(); expand(2'd3, 1'b0, 12'h0, 48'h123456);
`ifdef INS_COMPRESS_EN
    pin("m_wait", 3, {16'h2123, 16'h4456, 16'hA000, 32'h0});
    xq.delete(); expand(2'd3, 1'b0, 12'h0, 48'h0);         pin("m_wait0", 2, {16'h2000, 16'hA000, 48'h0});
`else
    pin("m_wait", 5, {16'h2000, 16'h4000, 16'h4123, 16'h4456, 16'hA000});
`endif

    repeat (2) @(posedge fpga_clk_i);
    #1;
    check("rst_ready", {31'h0, bus.cmd_ready_o}, 32'h1);
    check("rst_wr",    {31'h0, bus.fifo_wr_o},   32'h0);
    check("rst_data",  {16'h0, bus.fifo_data_o}, 32'h0);
    check("rst_busy",  {31'h0, bus.busy_o},      32'h0);
    check("rst_cnt",   {16'h0, bus.word_cnt_o},  32'h0);
    @(negedge fpga_clk_i);
    reset_i = 1'b0;
    mon_en  = 1'b1;
    @(negedge fpga_clk_i);

    send(2'd1, 1'b0, 12'hABC, 48'h0);
    idle(3);
    check("t1_cnt", {16'h0, bus.word_cnt_o}, 32'd1);

    send(2'd2, 1'b1, 12'h012, 48'h5A5);
    idle(4);
    check("t2_cnt", {16'h0, bus.word_cnt_o}, 32'd3);

    send(2'd3, 1'b0, 12'h0, 48'h123456);
    idle(8);
`ifdef INS_COMPRESS_EN
    check("t3_cnt", {16'h0, bus.word_cnt_o}, 32'd6);
`else
    check("t3_cnt", {16'h0, bus.word_cnt_o}, 32'd8);
`endif

    send(2'd3, 1'b0, 12'h0, 48'h0);
    bus.cmd_valid_i = 1'b0;
    @(negedge fpga_clk_i);
    bus.fifo_full_i = 1'b1;
    repeat (3) @(negedge fpga_clk_i);
    bus.fifo_full_i = 1'b0;
    idle(8);

    send(2'd0, 1'b0, 12'h0, 48'hBEEF);
    send(2'd1, 1'b0, 12'h001, 48'h0);
    idle(6);

    send(2'd3, 1'b0, 12'h0, 48'h123456);
    bus.cmd_valid_i = 1'b0;
    @(posedge fpga_clk_i);
    @(posedge fpga_clk_i);
    #3;
    mon_en  = 1'b0;
    reset_i = 1'b1;
    #1;
    check("t6_rst_wr",  {31'h0, bus.fifo_wr_o},  32'h0);
    check("t6_rst_cnt", {16'h0, bus.word_cnt_o}, 32'h0);
    @(negedge fpga_clk_i);
    reset_i = 1'b0;
    pend.delete();
    act.delete();
    acc_now = 1'b0;
    mcnt    = 16'd0;
    mon_en  = 1'b1;
    @(negedge fpga_clk_i);
    check("t6_ready", {31'h0, bus.cmd_ready_o}, 32'h1);
    send(2'd1, 1'b0, 12'h00F, 48'h0);
    idle(3);
    check("t6_cnt", {16'h0, bus.word_cnt_o}, 32'd1);

    rnd_full = 1'b1;
    for (int k = 0; k < 150; k++) begin
      op = 2'($urandom_range(3));
      for (int i = 0; i < 4; i++) v[12*i +: 12] = ($urandom_range(1) == 1) ? 12'($urandom) : 12'h000;
      send(op, 1'($urandom_range(1)), 12'($urandom), v);
      if ($urandom_range(3) == 0) idle($urandom_range(4));
    end
    bus.cmd_valid_i = 1'b0;
    rnd_full = 1'b0;
    @(negedge fpga_clk_i);
    bus.fifo_full_i = 1'b0;
    guard = 0;
    while ((act.size() > 0 || pend.size() > 0) && guard < 50) begin
      @(negedge fpga_clk_i);
      guard++;
    end
    @(negedge fpga_clk_i);
    check("drain", act.size() + pend.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
